// File: rtl/fractal_sync_pkg.sv
// Shared helpers for the fractal_sync tree: pointer arithmetic reused by the
// per-port queues and arbiter-side blocks.
package fractal_sync_pkg;

  // Increment with explicit wrap at depth-1; valid for non-power-of-two depths.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fractal_sync_fifo.sv
// Per-port first-word fall-through queue of synchronization elements feeding
// one arbiter input; sticky overflow/underflow flags cleared by flush.
module fractal_sync_fifo
  import fractal_sync_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         fsync_t = logic,
  parameter int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  fsync_t           element_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output fsync_t           element_o,
  output logic [LVL_W-1:0] level_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] MaxLvl = LVL_W'(DEPTH);

  if (DEPTH == 0) begin : g_depth_check
    $fatal(1, "fractal_sync_fifo: DEPTH must be greater than 0");
  end

  fsync_t            r_mem [DEPTH];
  logic [PtrW-1:0]   r_rd_ptr_q, r_rd_ptr_d;
  logic [PtrW-1:0]   r_wr_ptr_q, r_wr_ptr_d;
  logic [LVL_W-1:0]  r_level_q, r_level_d;
  logic              r_ovf_q, r_ovf_d;
  logic              r_udf_q, r_udf_d;

  logic w_empty, w_full, w_pop_eff, w_push_eff;

  assign w_empty    = (r_level_q == '0);
  assign w_full     = (r_level_q == MaxLvl);
  assign w_pop_eff  = pop_i & ~w_empty & ~flush_i;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push_eff = push_i & ~flush_i & (~w_full | w_pop_eff);

  always_comb begin
    r_rd_ptr_d = r_rd_ptr_q;
    r_wr_ptr_d = r_wr_ptr_q;
    r_level_d  = r_level_q;
    r_ovf_d    = r_ovf_q;
    r_udf_d    = r_udf_q;
    if (flush_i) begin
      r_rd_ptr_d = '0;
      r_wr_ptr_d = '0;
      r_level_d  = '0;
      r_ovf_d    = 1'b0;
      r_udf_d    = 1'b0;
    end else begin
      if (w_pop_eff) begin
        r_rd_ptr_d = PtrW'(ptr_inc(32'(r_rd_ptr_q), DEPTH));
      end
      if (w_push_eff) begin
        r_wr_ptr_d = PtrW'(ptr_inc(32'(r_wr_ptr_q), DEPTH));
      end
      if (w_push_eff && !w_pop_eff) begin
        r_level_d = r_level_q + LVL_W'(1);
      end else if (w_pop_eff && !w_push_eff) begin
        r_level_d = r_level_q - LVL_W'(1);
      end
      if (push_i && !w_push_eff) begin
        r_ovf_d = 1'b1;
      end
      if (pop_i && w_empty) begin
        r_udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr_q <= '0;
      r_wr_ptr_q <= '0;
      r_level_q  <= '0;
      r_ovf_q    <= 1'b0;
      r_udf_q    <= 1'b0;
    end else begin
      r_rd_ptr_q <= r_rd_ptr_d;
      r_wr_ptr_q <= r_wr_ptr_d;
      r_level_q  <= r_level_d;
      r_ovf_q    <= r_ovf_d;
      r_udf_q    <= r_udf_d;
    end
  end

  // Storage is intentionally left out of reset; validity is tracked by the level.
  always_ff @(posedge clk_i) begin
    if (w_push_eff) begin
      r_mem[r_wr_ptr_q] <= element_i;
    end
  end

  assign empty_o     = w_empty;
  assign full_o      = w_full;
  assign level_o     = r_level_q;
  assign overflow_o  = r_ovf_q;
  assign underflow_o = r_udf_q;
  assign element_o   = w_empty ? '0 : r_mem[r_rd_ptr_q];

  level_bound_a : assert property (@(posedge clk_i) disable iff (!rst_ni) r_level_q <= MaxLvl);

endmodule

// File: tb/tb_fractal_sync_fifo.sv
// Scoreboard bench for fractal_sync_fifo at DEPTH 4, 3 and 1 sharing one input bus.
module tb_fractal_sync_fifo;

  typedef logic [7:0] elem_t;

  logic  clk_i = 1'b0;
  logic  rst_ni;
  logic  flush, push, pop, arb_mode;
  elem_t elem_in;
  logic  pop4;

  logic full4, empty4, ovf4, udf4;
  logic full3, empty3, ovf3, udf3;
  logic full1, empty1, ovf1, udf1;
  elem_t out4, out3, out1;
  logic [2:0] lvl4;
  logic [1:0] lvl3;
  logic [0:0] lvl1;

  elem_t sb[$];
  elem_t exp_e;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  // Arbiter model for the DEPTH=4 instance: pop whenever not empty.
  assign pop4 = arb_mode ? ~empty4 : pop;

  fractal_sync_fifo #(.DEPTH(4), .fsync_t(elem_t)) u_dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush), .push_i(push), .element_i(elem_in),
    .full_o(full4), .pop_i(pop4), .empty_o(empty4), .element_o(out4), .level_o(lvl4),
    .overflow_o(ovf4), .underflow_o(udf4)
  );

  fractal_sync_fifo #(.DEPTH(3), .fsync_t(elem_t)) u_dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush), .push_i(push), .element_i(elem_in),
    .full_o(full3), .pop_i(pop), .empty_o(empty3), .element_o(out3), .level_o(lvl3),
    .overflow_o(ovf3), .underflow_o(udf3)
  );

  fractal_sync_fifo #(.DEPTH(1), .fsync_t(elem_t)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush), .push_i(push), .element_i(elem_in),
    .full_o(full1), .pop_i(pop), .empty_o(empty1), .element_o(out1), .level_o(lvl1),
    .overflow_o(ovf1), .underflow_o(udf1)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
  endtask

  task automatic fill4(input elem_t base);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; pop = 1'b0; elem_in = base + elem_t'(i);
      sb.push_back(elem_in);
      tick();
    end
    push = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    #2;
    n_checks++;
    if ({empty4, full4, lvl4, out4, ovf4, udf4} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset4: empty=%b full=%b lvl=%0d out=%h ovf=%b udf=%b", empty4, full4,
               lvl4, out4, ovf4, udf4);
    end
    n_checks++;
    if ({empty3, empty1, full1, out1} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset31: empty3=%b empty1=%b full1=%b out1=%h want 1 1 0 00",
               empty3, empty1, full1, out1);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    do_flush();
    push = 1'b1; elem_in = 8'hA0; sb.push_back(elem_in);
    tick();
    n_checks++;
    if (out4 !== 8'hA0 || lvl4 !== 3'd1) begin
      n_fail++; $display("FAIL first_visible: out=%h lvl=%0d want a0 1", out4, lvl4);
    end
    for (int i = 1; i < 4; i++) begin
      elem_in = 8'hA0 + elem_t'(i); sb.push_back(elem_in);
      tick();
    end
    push = 1'b0;
    n_checks++;
    if (full4 !== 1'b1 || lvl4 !== 3'd4) begin
      n_fail++; $display("FAIL fill_full: full=%b lvl=%0d want 1 4", full4, lvl4);
    end
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      exp_e = sb.pop_front();
      n_checks++;
      if (out4 !== exp_e) begin
        n_fail++; $display("FAIL drain_elem%0d: got %h want %h", i, out4, exp_e);
      end
      tick();
    end
    pop = 1'b0;
    n_checks++;
    if (empty4 !== 1'b1 || out4 !== 8'h00) begin
      n_fail++; $display("FAIL drain_empty: empty=%b out=%h want 1 00", empty4, out4);
    end
  endtask

  task automatic test_wrap();
    do_flush();
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; elem_in = 8'h30 + elem_t'(i);
      pop = (i >= 2);
      if (i >= 2) begin
        exp_e = sb.pop_front();
        n_checks++;
        if (out3 !== exp_e) begin
          n_fail++; $display("FAIL wrap_elem%0d: got %h want %h", i, out3, exp_e);
        end
      end
      sb.push_back(elem_in);
      tick();
      n_checks++;
      if (lvl3 !== ((i == 0) ? 2'd1 : 2'd2)) begin
        n_fail++; $display("FAIL wrap_level%0d: got %0d", i, lvl3);
      end
    end
    push = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pop = 1'b1;
      exp_e = sb.pop_front();
      n_checks++;
      if (out3 !== exp_e) begin
        n_fail++; $display("FAIL wrap_tail%0d: got %h want %h", i, out3, exp_e);
      end
      tick();
    end
    pop = 1'b0;
    n_checks++;
    if (empty3 !== 1'b1 || ovf3 !== 1'b0 || udf3 !== 1'b0) begin
      n_fail++; $display("FAIL wrap_end: empty=%b ovf=%b udf=%b want 1 0 0", empty3, ovf3, udf3);
    end
  endtask

  task automatic test_full_push_pop();
    do_flush();
    fill4(8'hB0);
    push = 1'b1; pop = 1'b1; elem_in = 8'hBE;
    exp_e = sb.pop_front();
    n_checks++;
    if (out4 !== exp_e) begin
      n_fail++; $display("FAIL fpp_head: got %h want %h", out4, exp_e);
    end
    sb.push_back(elem_in);
    tick();
    idle();
    n_checks++;
    if (lvl4 !== 3'd4 || ovf4 !== 1'b0 || full4 !== 1'b1) begin
      n_fail++; $display("FAIL fpp_state: lvl=%0d ovf=%b full=%b want 4 0 1", lvl4, ovf4, full4);
    end
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      exp_e = sb.pop_front();
      n_checks++;
      if (out4 !== exp_e) begin
        n_fail++; $display("FAIL fpp_drain%0d: got %h want %h", i, out4, exp_e);
      end
      tick();
    end
    pop = 1'b0;
  endtask

  task automatic test_errors();
    do_flush();
    fill4(8'hC0);
    push = 1'b1; elem_in = 8'hCF;
    tick();
    push = 1'b0;
    n_checks++;
    if (ovf4 !== 1'b1 || lvl4 !== 3'd4 || udf4 !== 1'b0) begin
      n_fail++; $display("FAIL overflow: ovf=%b lvl=%0d udf=%b want 1 4 0", ovf4, lvl4, udf4);
    end
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      exp_e = sb.pop_front();
      n_checks++;
      if (out4 !== exp_e) begin
        n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", i, out4, exp_e);
      end
      tick();
    end
    n_checks++;
    if (udf4 !== 1'b0 || empty4 !== 1'b1) begin
      n_fail++; $display("FAIL pre_underflow: udf=%b empty=%b want 0 1", udf4, empty4);
    end
    tick();
    pop = 1'b0;
    n_checks++;
    if (udf4 !== 1'b1 || lvl4 !== 3'd0) begin
      n_fail++; $display("FAIL underflow: udf=%b lvl=%0d want 1 0", udf4, lvl4);
    end
    tick(); tick();
    n_checks++;
    if (ovf4 !== 1'b1 || udf4 !== 1'b1) begin
      n_fail++; $display("FAIL flags_hold: ovf=%b udf=%b want 1 1", ovf4, udf4);
    end
    do_flush();
    n_checks++;
    if (ovf4 !== 1'b0 || udf4 !== 1'b0) begin
      n_fail++; $display("FAIL flags_flush: ovf=%b udf=%b want 0 0", ovf4, udf4);
    end
  endtask

  task automatic test_flush_priority();
    do_flush();
    push = 1'b1;
    elem_in = 8'hD0; tick();
    elem_in = 8'hD1; tick();
    flush = 1'b1; push = 1'b1; pop = 1'b1; elem_in = 8'hDD;
    tick();
    idle();
    n_checks++;
    if ({lvl4, empty4, ovf4, udf4, out4} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL flush_prio: lvl=%0d empty=%b ovf=%b udf=%b out=%h want 0 1 0 0 00",
               lvl4, empty4, ovf4, udf4, out4);
    end
    tick();
    n_checks++;
    if (empty4 !== 1'b1 || out4 !== 8'h00) begin
      n_fail++; $display("FAIL flush_absent: empty=%b out=%h want 1 00", empty4, out4);
    end
  endtask

  task automatic test_depth1();
    do_flush();
    push = 1'b1; elem_in = 8'hE0;
    tick();
    n_checks++;
    if ({full1, empty1, out1} !== {1'b1, 1'b0, 8'hE0}) begin
      n_fail++; $display("FAIL d1_fill: full=%b empty=%b out=%h want 1 0 e0", full1, empty1, out1);
    end
    pop = 1'b1; elem_in = 8'hE1;
    tick();
    n_checks++;
    if ({full1, out1, ovf1} !== {1'b1, 8'hE1, 1'b0}) begin
      n_fail++; $display("FAIL d1_replace: full=%b out=%h ovf=%b want 1 e1 0", full1, out1, ovf1);
    end
    pop = 1'b0; elem_in = 8'hE2;
    tick();
    n_checks++;
    if (ovf1 !== 1'b1 || out1 !== 8'hE1) begin
      n_fail++; $display("FAIL d1_overflow: ovf=%b out=%h want 1 e1", ovf1, out1);
    end
    push = 1'b0; pop = 1'b1;
    tick();
    pop = 1'b0;
    n_checks++;
    if (empty1 !== 1'b1 || out1 !== 8'h00 || lvl1 !== 1'b0) begin
      n_fail++; $display("FAIL d1_empty: empty=%b out=%h lvl=%0d want 1 00 0", empty1, out1, lvl1);
    end
  endtask

  task automatic test_arbiter();
    int sent, got, max_lvl;
    do_flush();
    arb_mode = 1'b1; sent = 0; got = 0; max_lvl = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (int'(lvl4) > max_lvl) max_lvl = int'(lvl4);
      if (!empty4) begin
        exp_e = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
        n_checks++;
        if (out4 !== exp_e) begin
          n_fail++; $display("FAIL arb_elem%0d: got %h want %h", got, out4, exp_e);
        end
        got++;
      end
      push = (sent < 8);
      if (sent < 8) begin
        elem_in = 8'h80 + elem_t'(sent); sb.push_back(elem_in); sent++;
      end
      tick();
    end
    push = 1'b0;
    n_checks++;
    if (got != 8 || max_lvl > 1) begin
      n_fail++; $display("FAIL arb_stream: received %0d max_level %0d want 8 and <=1", got, max_lvl);
    end
    // Second stream, reset asserted asynchronously mid-cycle after three elements.
    do_flush();
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      if (!empty4) begin
        exp_e = sb.pop_front();
        n_checks++;
        if (out4 !== exp_e) begin
          n_fail++; $display("FAIL arb2_elem%0d: got %h want %h", got, out4, exp_e);
        end
        got++;
      end
      push = 1'b1; elem_in = 8'h90 + elem_t'(sent); sb.push_back(elem_in); sent++;
      tick();
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({empty4, full4, lvl4, out4, ovf4, udf4} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL arb_reset: empty=%b full=%b lvl=%0d out=%h ovf=%b udf=%b", empty4, full4,
               lvl4, out4, ovf4, udf4);
    end
    push = 1'b0;
    sb.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(); tick();
    n_checks++;
    if (empty4 !== 1'b1 || lvl4 !== 3'd0) begin
      n_fail++; $display("FAIL arb_post_reset: empty=%b lvl=%0d want 1 0", empty4, lvl4);
    end
    arb_mode = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b1; arb_mode = 1'b0; elem_in = '0;
    idle();
    #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_push_pop();
    test_errors();
    test_flush_priority();
    test_depth1();
    test_arbiter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
